vc_test_mode_delay: RTL and testbench

//  Val/rdy test delay stage with selectable delay mode: fixed, pseudo-random bounded, or burst.

---
 rtl/vc_test_mode_delay_pkg.sv | 32 +++
 rtl/vc_test_mode_delay_lfsr.sv | 27 ++
 rtl/vc_test_mode_delay.sv | 139 +++++++++++++
 tb/tb_vc_test_mode_delay.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_test_mode_delay_pkg.sv
// Shared definitions for the val/rdy test delay stage: delay-mode encodings,
// FSM state encoding and the LFSR feedback taps used by the random mode.
package vc_test_mode_delay_pkg;

    // Delay-mode encodings as presented on the delay_mode port
    typedef enum logic [1:0] {
        DELAY_MODE_FIXED  = 2'd0,
        DELAY_MODE_RANDOM = 2'd1,
        DELAY_MODE_BURST  = 2'd2,
        DELAY_MODE_RSVD   = 2'd3
    } delay_mode_e;

    // Delay FSM states
    typedef enum logic {
        STATE_IDLE  = 1'b0,
        STATE_DELAY = 1'b1
    } state_e;

    // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 in right-shift form
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Bounded random delay; an all-ones bound uses the LFSR value directly so
    // the +1 in the modulus never wraps to zero.
    function automatic logic [31:0] random_delay(input logic [31:0] lfsr_val,
                                                 input logic [31:0] max_delay);
        if (max_delay == 32'hffff_ffff)
            return lfsr_val;
        else
            return lfsr_val % (max_delay + 32'd1);
    endfunction

endpackage

// File: rtl/vc_test_mode_delay_lfsr.sv
// Galois LFSR that advances one step per enabled cycle. A zero seed would
// lock the register at zero, so reset substitutes the value 1 in that case.
module vc_test_lfsr
    import vc_test_mode_delay_pkg::*;
#(
    parameter int                 p_nbits = 32,
    parameter logic [p_nbits-1:0] p_taps  = p_nbits'(LFSR_TAPS),
    parameter logic [p_nbits-1:0] p_seed  = p_nbits'(32'hb9b9_b9b9)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic [p_nbits-1:0] out
);

    localparam logic [p_nbits-1:0] c_reset_val =
        (p_seed == '0) ? p_nbits'(1) : p_seed;

    // Shift right each enabled cycle, folding the taps in when a one falls out
    always_ff @(posedge clk) begin
        if (reset)
            out <= c_reset_val;
        else if (en)
            out <= out[0] ? ((out >> 1) ^ p_taps) : (out >> 1);
    end

endmodule

// File: rtl/vc_test_mode_delay.sv
// Val/rdy test delay stage. Each message is held off for a delay chosen when
// it first arrives (fixed, bounded random or burst pattern) and is then passed
// straight through; the payload itself is never registered.
module vc_test_mode_delay
    import vc_test_mode_delay_pkg::*;
#(
    parameter int          p_msg_nbits = 1,
    parameter logic [31:0] p_seed      = 32'hb9b9_b9b9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             delay_mode,
    input  logic [31:0]            delay_amt,
    input  logic [31:0]            burst_len,
    input  logic                   in_val,
    output logic                   in_rdy,
    input  logic [p_msg_nbits-1:0] in_msg,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [p_msg_nbits-1:0] out_msg,
    output logic [31:0]            xfer_count
);

    state_e      state;
    state_e      state_next;
    logic [31:0] delay_cnt;
    logic [31:0] delay_cnt_next;
    logic [31:0] burst_cnt;
    logic [31:0] lfsr_out;
    logic [31:0] eff_delay;
    logic [1:0]  delay_mode_q;
    logic        ready_to_pass;
    logic        xfer;
    logic        mode_changed;

    vc_test_lfsr #(
        .p_nbits (32),
        .p_taps  (LFSR_TAPS),
        .p_seed  (p_seed)
    ) lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (xfer),
        .out   (lfsr_out)
    );

    assign mode_changed = (delay_mode != delay_mode_q);

    // Delay the next message would get if it were accepted in IDLE this cycle
    always_comb begin
        eff_delay = delay_amt;
        case (delay_mode_e'(delay_mode))
            DELAY_MODE_RANDOM: eff_delay = random_delay(lfsr_out, delay_amt);
            DELAY_MODE_BURST:  eff_delay = (burst_cnt < burst_len) ? 32'd0 : delay_amt;
            default:           eff_delay = delay_amt;
        endcase
    end

    // Message may pass once its delay has run out; reset blocks any transfer
    always_comb begin
        ready_to_pass = 1'b0;
        if (!reset) begin
            if (state == STATE_IDLE)
                ready_to_pass = (eff_delay == 32'd0);
            else
                ready_to_pass = (delay_cnt == 32'd0);
        end
    end

    assign out_val = in_val  && ready_to_pass;
    assign in_rdy  = out_rdy && ready_to_pass;
    assign xfer    = out_val && out_rdy;
    assign out_msg = out_val ? in_msg : {p_msg_nbits{1'bx}};

    // Next-state and countdown logic for the IDLE/DELAY handshake FSM
    always_comb begin
        state_next     = state;
        delay_cnt_next = delay_cnt;
        case (state)
            STATE_IDLE: begin
                if (in_val && !(out_rdy && (eff_delay == 32'd0))) begin
                    state_next     = STATE_DELAY;
                    delay_cnt_next = (eff_delay != 32'd0) ? eff_delay - 32'd1 : 32'd0;
                end
            end
            STATE_DELAY: begin
                if (delay_cnt != 32'd0)
                    delay_cnt_next = delay_cnt - 32'd1;
                if (xfer)
                    state_next = STATE_IDLE;
            end
            default: begin
                state_next     = STATE_IDLE;
                delay_cnt_next = 32'd0;
            end
        endcase
    end

    // FSM state and countdown registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= STATE_IDLE;
            delay_cnt <= 32'd0;
        end else begin
            state     <= state_next;
            delay_cnt <= delay_cnt_next;
        end
    end

    // Previous mode, so a mode switch can restart the burst pattern
    always_ff @(posedge clk) begin
        delay_mode_q <= delay_mode;
    end

    // Position within the current burst; wraps after the stall message
    always_ff @(posedge clk) begin
        if (reset || mode_changed)
            burst_cnt <= 32'd0;
        else if (xfer && (delay_mode == DELAY_MODE_BURST))
            burst_cnt <= (burst_cnt >= burst_len) ? 32'd0 : burst_cnt + 32'd1;
    end

    // Running count of completed transfers, wrapping naturally at 2^32
    always_ff @(posedge clk) begin
        if (reset)
            xfer_count <= 32'd0;
        else if (xfer)
            xfer_count <= xfer_count + 32'd1;
    end

    // Control inputs and handshake signals must never be unknown outside reset
    assert property (@(posedge clk) disable iff (reset)
        !$isunknown({delay_mode, delay_amt, in_val, in_rdy, out_val, out_rdy}));

    // A source must keep its message valid until the delayed transfer happens
    assert property (@(posedge clk) disable iff (reset)
        (state == STATE_DELAY) |-> in_val);

endmodule

// File: tb/tb_vc_test_mode_delay.sv
// Directed bench for vc_test_mode_delay: a vector table for the IDLE pass/stall
// decision plus hand-written multi-cycle sequences for each delay mode.
module tb_vc_test_mode_delay;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  delay_mode;
    logic [31:0] delay_amt;
    logic [31:0] burst_len;
    logic        in_val;
    logic        in_rdy;
    logic [7:0]  in_msg;
    logic        out_val;
    logic        out_rdy;
    logic [7:0]  out_msg;
    logic [31:0] xfer_count;

    int num_compared   = 0;
    int num_mismatched = 0;

    localparam logic [1:0] FIXED  = 2'd0;
    localparam logic [1:0] RANDOM = 2'd1;
    localparam logic [1:0] BURST  = 2'd2;
    localparam logic [1:0] RSVD   = 2'd3;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] amt;
        logic [31:0] blen;
        logic        iv;
        logic        ordy;
        logic        exp_in_rdy;
        logic        exp_out_val;
    } vec_t;

    vec_t vecs[11];

    vc_test_mode_delay #(
        .p_msg_nbits (8),
        .p_seed      (32'hb9b9_b9b9)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .delay_mode (delay_mode),
        .delay_amt  (delay_amt),
        .burst_len  (burst_len),
        .in_val     (in_val),
        .in_rdy     (in_rdy),
        .in_msg     (in_msg),
        .out_val    (out_val),
        .out_rdy    (out_rdy),
        .out_msg    (out_msg),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lfsrStep(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_compared++;
        if (actual !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic doReset(input logic [1:0] mode, input logic [31:0] amt,
                           input logic [31:0] blen);
        reset      = 1'b1;
        in_val     = 1'b0;
        out_rdy    = 1'b1;
        delay_mode = mode;
        delay_amt  = amt;
        burst_len  = blen;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        doReset(v.mode, v.amt, v.blen);
        in_val  = v.iv;
        out_rdy = v.ordy;
        #1;
    endtask

    // Present msg from a negedge and hold it until it transfers; returns the
    // number of whole cycles it waited (-1 on timeout) and leaves us at a negedge.
    task automatic sendMsg(input logic [7:0] msg, input int limit, output int delay);
        delay  = -1;
        in_val = 1'b1;
        in_msg = msg;
        for (int c = 0; c <= limit; c++) begin
            #1;
            if (out_val && out_rdy) begin
                delay = c;
                checkOutput("xfer_msg", {24'd0, out_msg}, {24'd0, msg});
            end
            @(negedge clk);
            if (delay >= 0)
                break;
        end
        in_val = 1'b0;
        if (delay < 0) begin
            num_compared++;
            num_mismatched++;
            $display("[TB] FAIL xfer_timeout: msg 0x%0h got no transfer, expected one within %0d cycles",
                     msg, limit);
        end
    endtask

    initial begin
        int          d;
        logic [31:0] model;
        int          exp4[6];

        reset      = 1'b1;
        delay_mode = FIXED;
        delay_amt  = 32'd0;
        burst_len  = 32'd0;
        in_val     = 1'b0;
        in_msg     = 8'h00;
        out_rdy    = 1'b1;

        vecs[0]  = '{FIXED,  32'd0,          32'd0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{FIXED,  32'd0,          32'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{FIXED,  32'd0,          32'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{FIXED,  32'd5,          32'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{RANDOM, 32'd0,          32'd0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[5]  = '{RANDOM, 32'hffff_ffff,  32'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{RANDOM, 32'd1,          32'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{BURST,  32'd4,          32'd2, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{BURST,  32'd3,          32'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{RSVD,   32'd0,          32'd0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{RSVD,   32'd2,          32'd0, 1'b1, 1'b1, 1'b0, 1'b0};

        $display("[TB] starting vc_test_mode_delay bench");

        // Reset state
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("reset_xfer_count", xfer_count, 32'd0);
        checkOutput("reset_in_rdy",     {31'd0, in_rdy},  32'd1);
        checkOutput("reset_out_val",    {31'd0, out_val}, 32'd0);

        // IDLE pass/stall decision table
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_in_rdy", i),  {31'd0, in_rdy},  {31'd0, vecs[i].exp_in_rdy});
            checkOutput($sformatf("vec%0d_out_val", i), {31'd0, out_val}, {31'd0, vecs[i].exp_out_val});
            in_val = 1'b0;
        end

        // Zero delay: one transfer per cycle
        doReset(FIXED, 32'd0, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            sendMsg(8'(i), 2, d);
            checkOutput("t1_delay", d, 32'd0);
        end
        #1;
        checkOutput("t1_xfer_count", xfer_count, 32'd4);

        // Fixed delay 3: out_val rises on cycle 3
        doReset(FIXED, 32'd3, 32'd0);
        @(negedge clk);
        in_val = 1'b1;
        in_msg = 8'ha5;
        for (int c = 0; c <= 3; c++) begin
            #1;
            checkOutput($sformatf("t2_out_val_c%0d", c), {31'd0, out_val}, (c == 3) ? 32'd1 : 32'd0);
            if (c == 3)
                checkOutput("t2_msg", {24'd0, out_msg}, 32'h0000_00a5);
            @(negedge clk);
        end
        in_val = 1'b0;
        #1;
        checkOutput("t2_xfer_count", xfer_count, 32'd1);

        // Fixed delay 2 with a stalled sink until cycle 6
        doReset(FIXED, 32'd2, 32'd0);
        in_val = 1'b1;
        in_msg = 8'h3c;
        for (int c = 0; c <= 6; c++) begin
            out_rdy = (c >= 6);
            #1;
            checkOutput($sformatf("t3_out_val_c%0d", c), {31'd0, out_val}, (c >= 2) ? 32'd1 : 32'd0);
            checkOutput($sformatf("t3_in_rdy_c%0d", c),  {31'd0, in_rdy},  (c == 6) ? 32'd1 : 32'd0);
            if (c == 6)
                checkOutput("t3_msg", {24'd0, out_msg}, 32'h0000_003c);
            @(negedge clk);
        end
        in_val  = 1'b0;
        out_rdy = 1'b1;
        #1;
        checkOutput("t3_xfer_count", xfer_count, 32'd1);

        // Burst of two zero-delay messages then a stall of 4
        exp4 = '{0, 0, 4, 0, 0, 4};
        doReset(BURST, 32'd4, 32'd2);
        for (int i = 0; i < 6; i++) begin
            sendMsg(8'(8'h40 + i), 10, d);
            checkOutput($sformatf("t4_delay%0d", i), d, exp4[i]);
        end
        #1;
        checkOutput("t4_xfer_count", xfer_count, 32'd6);

        // A mode change restarts the burst pattern
        doReset(BURST, 32'd3, 32'd1);
        sendMsg(8'h11, 10, d);
        checkOutput("mc_delay0", d, 32'd0);
        sendMsg(8'h12, 10, d);
        checkOutput("mc_delay1", d, 32'd3);
        sendMsg(8'h13, 10, d);
        checkOutput("mc_delay2", d, 32'd0);
        delay_mode = FIXED;
        @(negedge clk);
        delay_mode = BURST;
        sendMsg(8'h14, 10, d);
        checkOutput("mc_delay_after_switch", d, 32'd0);

        // Random delays bounded by 7, following the seeded LFSR sequence
        doReset(RANDOM, 32'd7, 32'd0);
        model = 32'hb9b9_b9b9;
        for (int i = 0; i < 100; i++) begin
            sendMsg(8'(i), 12, d);
            checkOutput($sformatf("t5_delay%0d", i), d, model % 32'd8);
            checkOutput($sformatf("t5_range%0d", i), (d >= 0 && d <= 7) ? 32'd1 : 32'd0, 32'd1);
            model = lfsrStep(model);
        end
        #1;
        checkOutput("t5_xfer_count", xfer_count, 32'd100);

        // Reset two cycles into a five-cycle delay
        doReset(FIXED, 32'd5, 32'd0);
        in_val = 1'b1;
        in_msg = 8'h77;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("t6_out_val_in_reset", {31'd0, out_val}, 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        delay_amt = 32'd0;
        #1;
        checkOutput("t6_xfer_count", xfer_count, 32'd0);
        checkOutput("t6_idle_pass", {31'd0, out_val}, 32'd1);
        @(negedge clk);
        in_val = 1'b0;
        #1;
        checkOutput("t6_xfer_after", xfer_count, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
